// File: rtl/ball_motion.sv
// Ball physics for the tile renderer: accepts a shot, resolves its direction, then rolls an
// 8.8 fixed-point position with linear friction once per frame. Optional macro: BALL_BOUNCE_EN.

module cos_sin_lookup #(
  parameter int LATENCY = 1
) (
  input  logic        clk_in,
  input  logic [15:0] angle_in,
  output logic [8:0]  cos_abs,
  output logic        cos_sign,
  output logic [8:0]  sin_abs,
  output logic        sin_sign
);

  // Quarter-wave sine, 16 steps per quadrant, scaled to 256 and rounded to nearest.
  function automatic logic [8:0] quarter_sin(input logic [4:0] k);
    logic [8:0] v;
    case (k)
      5'd0:    v = 9'd0;
      5'd1:    v = 9'd25;
      5'd2:    v = 9'd50;
      5'd3:    v = 9'd74;
      5'd4:    v = 9'd98;
      5'd5:    v = 9'd121;
      5'd6:    v = 9'd142;
      5'd7:    v = 9'd162;
      5'd8:    v = 9'd181;
      5'd9:    v = 9'd198;
      5'd10:   v = 9'd213;
      5'd11:   v = 9'd226;
      5'd12:   v = 9'd237;
      5'd13:   v = 9'd245;
      5'd14:   v = 9'd251;
      5'd15:   v = 9'd255;
      5'd16:   v = 9'd256;
      default: v = 9'd0;
    endcase
    return v;
  endfunction

  logic [1:0]  w_quad;
  logic [3:0]  w_idx;
  logic [8:0]  w_lo;
  logic [8:0]  w_hi;
  logic [19:0] w_result;
  logic [19:0] r_pipe [LATENCY];

  assign w_quad = angle_in[15:14];
  assign w_idx  = angle_in[13:10];
  assign w_lo   = quarter_sin({1'b0, w_idx});
  assign w_hi   = quarter_sin(5'd16 - {1'b0, w_idx});

  // Packed as {cos_abs, cos_sign, sin_abs, sin_sign}.
  always_comb begin
    w_result = '0;
    case (w_quad)
      2'd0:    w_result = {w_hi, 1'b1, w_lo, 1'b1};
      2'd1:    w_result = {w_lo, 1'b0, w_hi, 1'b1};
      2'd2:    w_result = {w_hi, 1'b0, w_lo, 1'b0};
      default: w_result = {w_lo, 1'b1, w_hi, 1'b0};
    endcase
  end

  always_ff @(posedge clk_in) begin
    r_pipe[0] <= w_result;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign {cos_abs, cos_sign, sin_abs, sin_sign} = r_pipe[LATENCY-1];

endmodule

module ball_motion #(
  parameter int WIDTH          = 160,
  parameter int HEIGHT         = 90,
  parameter int START_X        = 20,
  parameter int START_Y        = 45,
  parameter int FRICTION       = 16,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        frame_tick,
  input  logic        shot_valid,
  output logic        shot_ready,
  input  logic [15:0] shot_angle,
  input  logic [3:0]  shot_power,
  output logic [7:0]  ballx,
  output logic [6:0]  bally,
  output logic        moving,
  output logic        shot_done
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_ROLL, S_DONE} state_t;

  localparam int WAIT_W = $clog2(LOOKUP_LATENCY + 2);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOOKUP_LATENCY);
  localparam logic [9:0]  FRIC    = 10'(FRICTION);
  localparam logic signed [16:0] X_MAX = 17'(WIDTH * 256 - 1);
  localparam logic signed [16:0] Y_MAX = 17'(HEIGHT * 256 - 1);
  localparam logic [15:0] X_EDGE  = 16'((WIDTH - 1) * 256);
  localparam logic [15:0] Y_EDGE  = 16'((HEIGHT - 1) * 256);
  localparam logic [15:0] X_START = 16'(START_X * 256);
  localparam logic [15:0] Y_START = 16'(START_Y * 256);

  state_t r_state;
  state_t w_next;

  logic [15:0]       r_angle;
  logic [9:0]        r_speed;
  logic [8:0]        r_cos_abs;
  logic [8:0]        r_sin_abs;
  logic              r_cos_sign;
  logic              r_sin_sign;
  logic [15:0]       r_pos_x;
  logic [15:0]       r_pos_y;
  logic [WAIT_W-1:0] r_wait;

  logic [8:0]         w_lk_cos_abs;
  logic [8:0]         w_lk_sin_abs;
  logic               w_lk_cos_sign;
  logic               w_lk_sin_sign;
  logic               w_accept;
  logic               w_launch_end;
  logic               w_step;
  logic [18:0]        w_prod_x;
  logic [18:0]        w_prod_y;
  logic [10:0]        w_dx;
  logic [10:0]        w_dy;
  logic signed [16:0] w_new_x;
  logic signed [16:0] w_new_y;
  logic               w_lo_x;
  logic               w_hi_x;
  logic               w_lo_y;
  logic               w_hi_y;
  logic               w_hit_x;
  logic               w_hit_y;
  logic [15:0]        w_clamp_x;
  logic [15:0]        w_clamp_y;
  logic               w_edge_stop;
  logic               w_stop;

  cos_sin_lookup #(.LATENCY(LOOKUP_LATENCY)) u_lookup (
    .clk_in   (pixel_clk_in),
    .angle_in (r_angle),
    .cos_abs  (w_lk_cos_abs),
    .cos_sign (w_lk_cos_sign),
    .sin_abs  (w_lk_sin_abs),
    .sin_sign (w_lk_sin_sign)
  );

  assign w_accept     = (r_state == S_IDLE) && shot_valid;
  assign w_launch_end = (r_state == S_LAUNCH) && (r_wait == WAIT_LAST);
  assign w_step       = (r_state == S_ROLL) && frame_tick;

  assign w_prod_x = 19'(r_speed) * 19'(r_cos_abs);
  assign w_prod_y = 19'(r_speed) * 19'(r_sin_abs);
  assign w_dx     = 11'(w_prod_x >> 8);
  assign w_dy     = 11'(w_prod_y >> 8);

  assign w_new_x = r_cos_sign ? signed'({1'b0, r_pos_x}) + signed'(17'(w_dx))
                              : signed'({1'b0, r_pos_x}) - signed'(17'(w_dx));
  assign w_new_y = r_sin_sign ? signed'({1'b0, r_pos_y}) + signed'(17'(w_dy))
                              : signed'({1'b0, r_pos_y}) - signed'(17'(w_dy));

  assign w_lo_x  = w_new_x < 17'sd0;
  assign w_hi_x  = w_new_x > X_MAX;
  assign w_lo_y  = w_new_y < 17'sd0;
  assign w_hi_y  = w_new_y > Y_MAX;
  assign w_hit_x = w_lo_x || w_hi_x;
  assign w_hit_y = w_lo_y || w_hi_y;

  assign w_clamp_x = w_lo_x ? '0 : (w_hi_x ? X_EDGE : w_new_x[15:0]);
  assign w_clamp_y = w_lo_y ? '0 : (w_hi_y ? Y_EDGE : w_new_y[15:0]);

`ifdef BALL_BOUNCE_EN
  assign w_edge_stop = 1'b0;
`else
  assign w_edge_stop = w_hit_x || w_hit_y;
`endif

  // Friction stop uses the pre-decrement speed, so the last step still moves by that speed.
  assign w_stop = w_edge_stop || (r_speed <= FRIC);

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (shot_valid)   w_next = S_LAUNCH;
      S_LAUNCH: if (w_launch_end) w_next = S_ROLL;
      S_ROLL:   if (frame_tick && w_stop) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    shot_ready = (r_state == S_IDLE);
    moving     = (r_state == S_LAUNCH) || (r_state == S_ROLL);
    shot_done  = (r_state == S_DONE);
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_angle    <= '0;
      r_speed    <= '0;
      r_cos_abs  <= '0;
      r_sin_abs  <= '0;
      r_cos_sign <= 1'b0;
      r_sin_sign <= 1'b0;
      r_pos_x    <= X_START;
      r_pos_y    <= Y_START;
      r_wait     <= '0;
    end else begin
      if (w_accept) begin
        r_angle <= shot_angle;
        r_speed <= {shot_power, 6'b0};
        r_wait  <= '0;
      end
      if (r_state == S_LAUNCH) begin
        r_wait <= r_wait + 1'b1;
      end
      if (w_launch_end) begin
        r_cos_abs  <= w_lk_cos_abs;
        r_sin_abs  <= w_lk_sin_abs;
        r_cos_sign <= w_lk_cos_sign;
        r_sin_sign <= w_lk_sin_sign;
      end
      if (w_step) begin
        r_pos_x <= w_clamp_x;
        r_pos_y <= w_clamp_y;
`ifdef BALL_BOUNCE_EN
        r_cos_sign <= r_cos_sign ^ w_hit_x;
        r_sin_sign <= r_sin_sign ^ w_hit_y;
`endif
        r_speed <= w_stop ? '0 : r_speed - FRIC;
      end
    end
  end

  assign ballx = r_pos_x[15:8];
  assign bally = r_pos_y[14:8];

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus random shots scored against
// a trigonometric reference model of the roll.

module tb_ball_motion;

  localparam int W = 160;
  localparam int H = 90;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        shot_valid;
  logic        e_tick;
  logic        e_valid;
  logic [15:0] shot_angle;
  logic [3:0]  shot_power;
  logic        shot_ready, moving, shot_done;
  logic [7:0]  ballx;
  logic [6:0]  bally;
  logic        e_ready, e_moving, e_done;
  logic [7:0]  e_ballx;
  logic [6:0]  e_bally;

  int checks = 0;
  int failures = 0;

  int m_x, m_y, m_speed, m_ca, m_sa;
  bit m_cs, m_ss;

  always #5 clk = ~clk;

  ball_motion u_dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .frame_tick   (frame_tick),
    .shot_valid   (shot_valid),
    .shot_ready   (shot_ready),
    .shot_angle   (shot_angle),
    .shot_power   (shot_power),
    .ballx        (ballx),
    .bally        (bally),
    .moving       (moving),
    .shot_done    (shot_done)
  );

  ball_motion #(.START_X(157)) u_edge (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .frame_tick   (e_tick),
    .shot_valid   (e_valid),
    .shot_ready   (e_ready),
    .shot_angle   (shot_angle),
    .shot_power   (shot_power),
    .ballx        (e_ballx),
    .bally        (e_bally),
    .moving       (e_moving),
    .shot_done    (e_done)
  );

  task automatic model_launch(input logic [15:0] ang, input logic [3:0] pw);
    real th, c, s;
    th = real'(ang[15:10]) * 5.625 * 3.14159265358979 / 180.0;
    c = $cos(th);
    s = $sin(th);
    m_ca = $rtoi(((c < 0.0) ? -c : c) * 256.0 + 0.5);
    m_sa = $rtoi(((s < 0.0) ? -s : s) * 256.0 + 0.5);
    m_cs = c > 0.0;
    m_ss = s > 0.0;
    m_speed = int'(pw) * 64;
  endtask

  task automatic model_step(output bit done);
    int dx, dy, nx, ny;
    bit hx, hy;
    dx = (m_speed * m_ca) / 256;
    dy = (m_speed * m_sa) / 256;
    nx = m_cs ? m_x + dx : m_x - dx;
    ny = m_ss ? m_y + dy : m_y - dy;
    hx = 0;
    hy = 0;
    if (nx < 0) begin nx = 0; hx = 1; end
    else if (nx > W * 256 - 1) begin nx = (W - 1) * 256; hx = 1; end
    if (ny < 0) begin ny = 0; hy = 1; end
    else if (ny > H * 256 - 1) begin ny = (H - 1) * 256; hy = 1; end
    m_x = nx;
    m_y = ny;
    done = 0;
`ifdef BALL_BOUNCE_EN
    if (hx) m_cs = !m_cs;
    if (hy) m_ss = !m_ss;
`else
    if (hx || hy) begin m_speed = 0; done = 1; end
`endif
    if (!done) begin
      if (m_speed <= 16) begin m_speed = 0; done = 1; end
      else m_speed -= 16;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; shot_valid = 0; frame_tick = 0; e_valid = 0; e_tick = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    m_x = 20 * 256;
    m_y = 45 * 256;
  endtask

  task automatic fire(input logic [15:0] ang, input logic [3:0] pw);
    int n = 0;
    while (!shot_ready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (shot_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_wait: shot_ready=%b required 1", shot_ready);
    end
    shot_angle = ang; shot_power = pw; shot_valid = 1;
    @(negedge clk);
    shot_valid = 0;
    checks++;
    if ({moving, shot_ready} !== 2'b10) begin
      failures++;
      $display("FAIL accept: moving,ready=%b required 10", {moving, shot_ready});
    end
    repeat (2) @(negedge clk);
    model_launch(ang, pw);
  endtask

  task automatic tick_and_check(input string tag, output bit done);
    frame_tick = 1;
    @(negedge clk);
    frame_tick = 0;
    model_step(done);
    checks++;
    if ({ballx, bally, shot_done} !== {8'(m_x >> 8), 7'(m_y >> 8), done}) begin
      failures++;
      $display("FAIL %s step: x=%0d y=%0d done=%b required x=%0d y=%0d done=%b",
               tag, ballx, bally, shot_done, m_x >> 8, m_y >> 8, done);
    end
    @(negedge clk);
    if (done) begin
      checks++;
      if ({shot_done, shot_ready, moving} !== 3'b010) begin
        failures++;
        $display("FAIL %s after_done: done,ready,moving=%b required 010",
                 tag, {shot_done, shot_ready, moving});
      end
    end
  endtask

  task automatic roll_to_end(input string tag, output int nticks);
    bit d = 0;
    nticks = 0;
    while (!d && nticks < 80) begin
      tick_and_check(tag, d);
      nticks++;
    end
    if (!d) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: ticks=%0d required done", tag, nticks);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({ballx, bally, shot_ready, moving, shot_done} !== {8'd20, 7'd45, 3'b100}) begin
      failures++;
      $display("FAIL reset: x=%0d y=%0d rdy=%b mov=%b done=%b required 20 45 1 0 0",
               ballx, bally, shot_ready, moving, shot_done);
    end
    checks++;
    if ({e_ballx, e_bally, e_ready} !== {8'd157, 7'd45, 1'b1}) begin
      failures++;
      $display("FAIL reset_edge: x=%0d y=%0d rdy=%b required 157 45 1", e_ballx, e_bally, e_ready);
    end
  endtask

  task automatic test_straight();
    int n;
    do_reset();
    fire(16'h0000, 4'd4);
    roll_to_end("straight", n);
    checks++;
    if ({ballx, bally, 8'(n)} !== {8'd28, 7'd45, 8'd16}) begin
      failures++;
      $display("FAIL straight_end: x=%0d y=%0d ticks=%0d required 28 45 16", ballx, bally, n);
    end
  endtask

  task automatic test_power_zero();
    int n;
    logic [7:0] x0;
    logic [6:0] y0;
    x0 = ballx; y0 = bally;
    fire(16'($urandom), 4'd0);
    roll_to_end("power0", n);
    checks++;
    if ({ballx, bally, 8'(n)} !== {x0, y0, 8'd1}) begin
      failures++;
      $display("FAIL power0_end: x=%0d y=%0d ticks=%0d required %0d %0d 1", ballx, bally, n, x0, y0);
    end
  endtask

  task automatic test_edge();
    do_reset();
    shot_angle = 16'h0000; shot_power = 4'd15; e_valid = 1;
    @(negedge clk);
    e_valid = 0;
    repeat (2) @(negedge clk);
    e_tick = 1;
    @(negedge clk);
    e_tick = 0;
    checks++;
    if ({e_ballx, e_bally} !== {8'd159, 7'd45}) begin
      failures++;
      $display("FAIL edge_tick1: x=%0d y=%0d required 159 45", e_ballx, e_bally);
    end
`ifdef BALL_BOUNCE_EN
    checks++;
    if (e_done !== 1'b0) begin
      failures++;
      $display("FAIL edge_nodone: done=%b required 0", e_done);
    end
    @(negedge clk);
    e_tick = 1;
    @(negedge clk);
    e_tick = 0;
    checks++;
    if (e_ballx !== 8'd155) begin
      failures++;
      $display("FAIL edge_bounce: x=%0d required 155", e_ballx);
    end
`else
    checks++;
    if (e_done !== 1'b1) begin
      failures++;
      $display("FAIL edge_stop: done=%b required 1", e_done);
    end
`endif
  endtask

  task automatic test_random();
    int n;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      fire(16'($urandom), 4'($urandom_range(15, 0)));
      roll_to_end("random", n);
    end
  endtask

  task automatic test_valid_and_reset();
    bit d;
    int seen;
    do_reset();
    fire(16'h0000, 4'd15);
    shot_angle = 16'h8000; shot_power = 4'd3; shot_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick_and_check("valid_held", d);
      checks++;
      if (shot_ready !== 1'b0) begin
        failures++;
        $display("FAIL valid_held_ready: shot_ready=%b required 0", shot_ready);
      end
    end
    shot_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_x = 20 * 256; m_y = 45 * 256;
    checks++;
    if ({ballx, bally, moving, shot_done} !== {8'd20, 7'd45, 2'b00}) begin
      failures++;
      $display("FAIL mid_reset: x=%0d y=%0d mov=%b done=%b required 20 45 0 0",
               ballx, bally, moving, shot_done);
    end
    seen = 0;
    repeat (6) begin @(negedge clk); if (shot_done) seen++; end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_reset_done: pulses=%0d required 0", seen);
    end
  endtask

  task automatic test_tick_in_launch();
    logic [15:0] ang;
    logic [3:0]  pw;
    int n;
    do_reset();
    ang = 16'($urandom);
    pw  = 4'($urandom_range(15, 1));
    shot_angle = ang; shot_power = pw; shot_valid = 1;
    @(negedge clk);
    shot_valid = 0; frame_tick = 1;
    repeat (2) @(negedge clk);
    frame_tick = 0;
    checks++;
    if ({ballx, bally, moving} !== {8'd20, 7'd45, 1'b1}) begin
      failures++;
      $display("FAIL launch_tick: x=%0d y=%0d mov=%b required 20 45 1", ballx, bally, moving);
    end
    model_launch(ang, pw);
    roll_to_end("after_launch", n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; frame_tick = 0; shot_valid = 0; e_tick = 0; e_valid = 0;
    shot_angle = '0; shot_power = '0;
    test_reset();
    test_straight();
    test_power_zero();
    test_edge();
    test_random();
    test_valid_and_reset();
    test_tick_in_launch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
